// File: rtl/plic_pkg.sv
// Shared definitions for the PLIC claim/arbitration slice.
// - claim_state_e : two-state claim handshake FSM encoding
// - CLAIM_NONE    : ID value meaning "no interrupt"
// - plic_id_width : width needed to hold IDs 0..n
package plic_pkg;

  typedef enum logic [0:0] {
    IDLE       = 1'b0,
    CLAIM_RESP = 1'b1
  } claim_state_e;

  localparam int CLAIM_NONE = 0;

  function automatic int plic_id_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/plic_gateway.sv
// Per-source interrupt gateway: holds the pending / in-service flop pair.
// Ports:
//   clk, n_rst     : clock, asynchronous active-low reset
//   i_irq          : level interrupt line of this source
//   i_claim        : this source is being claimed on this edge
//   i_complete     : a valid completion targets this source on this edge
//   o_pending      : source is waiting to be claimed
//   o_in_service   : source has been claimed and not yet completed
module plic_gateway (
  input  logic clk,
  input  logic n_rst,
  input  logic i_irq,
  input  logic i_claim,
  input  logic i_complete,
  output logic o_pending,
  output logic o_in_service
);

  logic r_pending;
  logic r_in_service;

  // Pending/in-service update; a claimed source cannot re-pend until completed.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_pending    <= 1'b0;
      r_in_service <= 1'b0;
    end else begin
      if (i_claim) begin
        r_pending <= 1'b0;
      end else if (i_irq && !r_pending && !r_in_service) begin
        r_pending <= 1'b1;
      end else begin
        r_pending <= r_pending;
      end

      if (i_claim) begin
        r_in_service <= 1'b1;
      end else if (i_complete) begin
        r_in_service <= 1'b0;
      end else begin
        r_in_service <= r_in_service;
      end
    end
  end

  assign o_pending    = r_pending;
  assign o_in_service = r_in_service;

endmodule

// File: rtl/plic_claim_arbiter.sv
// PLIC core scheduler for one hart target.
// Latches level interrupts into per-source pending bits, picks the highest
// priority enabled pending source (lowest ID on ties), drives the external
// interrupt line and sequences the claim/complete handshake.
// Ports:
//   clk, n_rst                  : clock, asynchronous active-low reset
//   irq_src[NUM_SOURCES]        : level interrupts, bit i is ID i+1
//   src_enable[NUM_SOURCES]     : per-source enable for this target
//   src_priority                : packed priorities, slice i is ID i+1
//   threshold                   : target priority threshold
//   claim_req / claim_valid     : claim read pulse / response pulse
//   claim_id[32]                : claimed ID (0 = none), held until next claim
//   complete_req / complete_id  : claim register write pulse / written ID
//   eip                         : external interrupt pending to the hart
//   pending                     : pending bits for read-back
module plic_claim_arbiter
  import plic_pkg::*;
#(
  parameter int NUM_SOURCES = 10,
  parameter int PRIO_WIDTH  = 3
) (
  input  logic                              clk,
  input  logic                              n_rst,
  input  logic [NUM_SOURCES-1:0]            irq_src,
  input  logic [NUM_SOURCES-1:0]            src_enable,
  input  logic [NUM_SOURCES*PRIO_WIDTH-1:0] src_priority,
  input  logic [PRIO_WIDTH-1:0]             threshold,
  input  logic                              claim_req,
  output logic                              claim_valid,
  output logic [31:0]                       claim_id,
  input  logic                              complete_req,
  input  logic [31:0]                       complete_id,
  output logic                              eip,
  output logic [NUM_SOURCES-1:0]            pending
);

  localparam int ID_WIDTH = plic_id_width(NUM_SOURCES);

  logic [NUM_SOURCES-1:0] w_pending;
  logic [NUM_SOURCES-1:0] w_in_service;
  logic [NUM_SOURCES-1:0] w_claim_hit;
  logic [NUM_SOURCES-1:0] w_complete_hit;
  logic [PRIO_WIDTH-1:0]  w_prio [NUM_SOURCES];

  logic [ID_WIDTH-1:0]    w_scan_id;
  logic [PRIO_WIDTH-1:0]  w_scan_prio;
  logic [ID_WIDTH-1:0]    w_grant_id;
  logic                   w_claim_fire;
  claim_state_e           w_state_next;

  claim_state_e           r_state;
  logic [ID_WIDTH-1:0]    r_best_id;
  logic [PRIO_WIDTH-1:0]  r_best_prio;
  logic                   r_eip;
  logic                   r_claim_valid;
  logic [31:0]            r_claim_id;

  for (genvar gi = 0; gi < NUM_SOURCES; gi++) begin : g_src
    assign w_prio[gi] = src_priority[gi*PRIO_WIDTH +: PRIO_WIDTH];

    // A grant of CLAIM_NONE never matches any source, so ID 0 claims touch nothing.
    assign w_claim_hit[gi] = w_claim_fire && (w_grant_id == ID_WIDTH'(gi + 1));

    // Full 32-bit compare: set upper bits make the ID out of range.
    assign w_complete_hit[gi] = complete_req && (complete_id == 32'(gi + 1))
                                && w_in_service[gi];

    plic_gateway u_gateway (
      .clk          (clk),
      .n_rst        (n_rst),
      .i_irq        (irq_src[gi]),
      .i_claim      (w_claim_hit[gi]),
      .i_complete   (w_complete_hit[gi]),
      .o_pending    (w_pending[gi]),
      .o_in_service (w_in_service[gi])
    );
  end

  // Priority scan: strictly-greater update keeps the lowest ID on ties and
  // drops priority-0 sources because the running maximum starts at 0.
  always_comb begin
    w_scan_id   = ID_WIDTH'(CLAIM_NONE);
    w_scan_prio = '0;
    for (int i = 0; i < NUM_SOURCES; i++) begin
      if (w_pending[i] && src_enable[i] && (w_prio[i] > w_scan_prio)) begin
        w_scan_id   = ID_WIDTH'(i + 1);
        w_scan_prio = w_prio[i];
      end else begin
        // not a better candidate: keep the current winner
      end
    end
  end

  // Claim FSM next-state and grant selection.
  always_comb begin
    w_state_next = r_state;
    w_claim_fire = 1'b0;
    w_grant_id   = ID_WIDTH'(CLAIM_NONE);
    case (r_state)
      IDLE: begin
        if (claim_req) begin
          w_claim_fire = 1'b1;
          w_state_next = CLAIM_RESP;
          if (r_best_prio > threshold) begin
            w_grant_id = r_best_id;
          end else begin
            w_grant_id = ID_WIDTH'(CLAIM_NONE);
          end
        end else begin
          w_state_next = IDLE;
        end
      end
      CLAIM_RESP: begin
        // claim_req ignored; best_* refreshes from the post-claim pending bits
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Claim FSM state register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Registered arbitration result, eip and claim response.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_best_id     <= '0;
      r_best_prio   <= '0;
      r_eip         <= 1'b0;
      r_claim_valid <= 1'b0;
      r_claim_id    <= 32'd0;
    end else begin
      r_best_id     <= w_scan_id;
      r_best_prio   <= w_scan_prio;
      // eip is held low for the whole response cycle of a claim
      r_eip         <= (w_state_next != CLAIM_RESP) && (w_scan_prio > threshold);
      r_claim_valid <= w_claim_fire;
      if (w_claim_fire) begin
        r_claim_id <= 32'(w_grant_id);
      end else begin
        r_claim_id <= r_claim_id;
      end
    end
  end

  assign claim_valid = r_claim_valid;
  assign claim_id    = r_claim_id;
  assign eip         = r_eip;
  assign pending     = w_pending;

endmodule
